wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter RF_DEPTH, default 32, number of architectural registers and width of the busy vector.
REQ-002 SHALL have parameter NUM_SRC, default 3, number of execution-unit result sources; only the value 3 is supported.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port alu_axis_if  axis_if.s  $bits(exwb_tdata_t)  ALU result stream; source index 0.
REQ-006 SHALL have port lsu_axis_if  axis_if.s  $bits(exwb_tdata_t)  load/store result stream; source index 1.
REQ-007 SHALL have port csr_axis_if  axis_if.s  $bits(exwb_tdata_t)  CSR/system result stream; source index 2.
REQ-008 SHALL have port wbrf_axis_if  axis_if.m  $bits(wbrf_tdata_t)  write-back stream to the register file.
REQ-009 SHALL have port issue_valid  input  1  an instruction with a destination register left the register-file stage this cycle.
REQ-010 SHALL have port issue_rd  input  5  destination register of that instruction.
REQ-011 SHALL have port busy  output  RF_DEPTH  per-register pending-write flags.
REQ-012 SHALL have port invalidate  input  1  pipeline flush.

Function
REQ-013 SHALL hold one output register (valid bit plus wbrf_tdata_t); wbrf_axis_if.tvalid and wbrf_axis_if.tdata SHALL be driven directly from it.
REQ-014 Output register "can load" SHALL be: valid clear, or (wbrf_axis_if.tvalid and wbrf_axis_if.tready).
REQ-015 On can-load with at least one source valid and invalidate low, SHALL grant exactly one source: the first valid source at or after the round-robin pointer, in index order mod 3.
REQ-016 SHALL assert tready only to the granted source, combinationally, in the grant cycle; all other tready signals SHALL be low.
REQ-017 Granted data SHALL appear on wbrf_axis_if on the next cycle (latency 1): wbrf_tdata.ex_data = source ex_data, wbrf_tdata.wdata = source result.
REQ-018 After a grant the pointer SHALL advance to (granted index + 1) mod 3; with no grant the pointer SHALL hold.
REQ-019 With no grant and the output consumed, the output valid bit SHALL clear; with the output stalled (tvalid and not tready), the data and valid bit SHALL hold unchanged.
REQ-020 With invalidate high, SHALL clear the output valid bit, grant no source (all tready low), and hold the pointer.
REQ-021 Scoreboard: issue_valid with issue_rd != 0 SHALL set busy[issue_rd] on the next edge.
REQ-022 Scoreboard: a write-back handshake SHALL clear busy[rd] for that rd.
REQ-023 Scoreboard: a simultaneous set and clear of the same rd SHALL leave the bit set.
REQ-024 busy[0] SHALL always be 0.
REQ-025 invalidate SHALL clear all busy bits; an issue_valid in the same cycle SHALL be ignored.

Reset
REQ-026 While rst is low at a rising edge, SHALL clear the output valid bit, set the pointer to 0, and clear busy to all zeros.
REQ-027 During reset all source tready signals SHALL be low; output data contents are don't-care.
REQ-028 Reset asserted mid-stall SHALL drop the held result without completing its handshake.

Configuration
REQ-029 Macro WB_SCOREBOARD_EN defined: the scoreboard (REQ-021..REQ-025) SHALL be compiled in.
REQ-030 Macro WB_SCOREBOARD_EN undefined: busy SHALL be tied to zero, issue_valid and issue_rd SHALL be ignored, and no scoreboard flops SHALL exist.

Structure
REQ-031 exwb_tdata_t ({ex_data, result[XLEN-1:0]}), wbrf_tdata_t, and constant WB_NUM_SRC = 3 SHALL live in offnariscv_pkg.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (request vector in, one-hot grant out, pointer state inside, advance on an accept strobe).

Verification
REQ-033 Scenario, priority order: ALU, LSU and CSR all valid every cycle, tready = 1 -> grants in order 0,1,2,0,1,2; each result appears on wbrf_axis_if exactly one cycle after its grant.
REQ-034 Scenario, stall: hold wbrf tready low for 3 cycles while LSU result 0x1234 (rd = 5) is in the output register -> tdata stable, all source tready low, wdata 0x1234 transfers on release.
REQ-035 Scenario, invalidate: pulse invalidate while the output is valid and ALU is valid -> output tvalid low next cycle, ALU not accepted that cycle, pointer unchanged.
REQ-036 Scenario, scoreboard set/clear: issue rd = 7 -> busy[7] = 1; write back rd = 7 together with a new issue of rd = 7 -> busy[7] stays 1; next write back of rd = 7 -> busy[7] = 0.
REQ-037 Scenario, register x0: issue rd = 0 -> busy stays 0x00000000; write back rd = 0 -> passes to wbrf_axis_if normally.
REQ-038 Scenario, reset: assert rst low mid-stall with busy = 0x000000A0 -> next cycle tvalid = 0, busy = 0, next grant goes to ALU (index 0).

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared write-back types for the offnariscv core: execute-to-writeback and
// writeback-to-register-file stream payloads.
package offnariscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WB_NUM_SRC = 3;

  typedef struct packed {
    logic [4:0] rd;
  } ex_data_t;

  typedef struct packed {
    ex_data_t          ex_data;
    logic [XLEN-1:0]   result;
  } exwb_tdata_t;

  typedef struct packed {
    ex_data_t          ex_data;
    logic [XLEN-1:0]   wdata;
  } wbrf_tdata_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Minimal AXI-stream style channel: m drives data/valid, s returns ready.
interface axis_if #(
  parameter int unsigned DATA_W = 32
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer; the pointer moves past the winner when i_accept is strobed.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_en,
  input  logic         i_accept,
  output logic [N-1:0] o_gnt
);
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = PTR_W'((k + r_ptr) % N);
      if (i_en && !w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    for (int unsigned k = 0; k < N; k++) begin
      if (o_gnt[k]) w_ptr_nxt = PTR_W'((k + 1) % N);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)          r_ptr <= '0;
    else if (i_accept) r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU/LSU/CSR result streams into one registered
// register-file write stream. Define WB_SCOREBOARD_EN to build the busy scoreboard.
module wb_arbiter
  import offnariscv_pkg::*;
#(
  parameter int unsigned RF_DEPTH = 32,
  parameter int unsigned NUM_SRC  = 3
) (
  input  logic                clk,
  input  logic                rst,
  axis_if.s                   alu_axis_if,
  axis_if.s                   lsu_axis_if,
  axis_if.s                   csr_axis_if,
  axis_if.m                   wbrf_axis_if,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rd,
  output logic [RF_DEPTH-1:0] busy,
  input  logic                invalidate
);

  logic               r_valid;
  wbrf_tdata_t        r_data;
  logic               w_can_load;
  logic               w_arb_en;
  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_gnt;
  logic               w_any_gnt;
  exwb_tdata_t        w_sel;

  assign w_can_load = !r_valid || (r_valid && wbrf_axis_if.tready);
  // Grants are suppressed in reset and on flush so no source handshake completes.
  assign w_arb_en   = rst && !invalidate && w_can_load;
  assign w_req      = {csr_axis_if.tvalid, lsu_axis_if.tvalid, alu_axis_if.tvalid};
  assign w_any_gnt  = |w_gnt;

  rr_arbiter #(
    .N (NUM_SRC)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .i_en     (w_arb_en),
    .i_accept (w_any_gnt),
    .o_gnt    (w_gnt)
  );

  assign alu_axis_if.tready = w_gnt[0];
  assign lsu_axis_if.tready = w_gnt[1];
  assign csr_axis_if.tready = w_gnt[2];

  always_comb begin
    w_sel = alu_axis_if.tdata;
    if (w_gnt[1]) w_sel = lsu_axis_if.tdata;
    if (w_gnt[2]) w_sel = csr_axis_if.tdata;
  end

  always_ff @(posedge clk) begin
    if (!rst)            r_valid <= 1'b0;
    else if (invalidate) r_valid <= 1'b0;
    else if (w_can_load) r_valid <= w_any_gnt;
  end

  always_ff @(posedge clk) begin
    if (w_any_gnt) begin
      r_data.ex_data <= w_sel.ex_data;
      r_data.wdata   <= w_sel.result;
    end
  end

  assign wbrf_axis_if.tvalid = r_valid;
  assign wbrf_axis_if.tdata  = r_data;

`ifdef WB_SCOREBOARD_EN
  logic [RF_DEPTH-1:0] r_busy;
  logic [RF_DEPTH-1:0] w_set;
  logic [RF_DEPTH-1:0] w_clr;
  logic                w_wb_fire;

  assign w_wb_fire = r_valid && wbrf_axis_if.tready;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid && (issue_rd != '0)) w_set[issue_rd] = 1'b1;
    if (w_wb_fire) w_clr[r_data.ex_data.rd] = 1'b1;
  end

  // Set is applied after clear so a same-cycle issue of the written rd wins.
  always_ff @(posedge clk) begin
    if (!rst)            r_busy <= '0;
    else if (invalidate) r_busy <= '0;
    else                 r_busy <= (r_busy & ~w_clr) | w_set;
  end

  assign busy = {r_busy[RF_DEPTH-1:1], 1'b0};
`else
  logic w_unused_issue;
  assign w_unused_issue = ^{issue_valid, issue_rd};
  assign busy = '0;
`endif

endmodule
